// File: rtl/sobel_loop_profiler.sv
// sobel_loop_profiler: on-chip loop statistics for the sobel_hls accelerator.
// Each monitored loop channel runs an IDLE/RUN tracker fed by that loop's
// start, done, iteration-accepted and stall qualifiers. Per invocation it
// records latency, iteration count and stall count, and it keeps a running
// invocation count. All counters saturate rather than wrap.
//
// Ports:
//   ap_clk, ap_rst_n  clock, asynchronous active-low reset
//   clear             synchronous clear of all state, counters and flags
//   ch_start/ch_done/ch_iter/ch_stall  per-channel loop handshakes
//   ch_busy           channel currently in RUN (registered)
//   done_evt          one-cycle pulse per completed invocation
//   proto_err         sticky: ch_done seen while the channel was IDLE
//   rd_en/rd_ch/rd_sel  read request; rd_sel 0=latency 1=iterations
//                       2=stalls 3=invocation count
//   rd_data/rd_valid  registered read response, one cycle after rd_en
module sobel_loop_profiler #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CH_W   = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_iter,
    input  logic [NUM_CH-1:0] ch_stall,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] done_evt,
    output logic [NUM_CH-1:0] proto_err,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [1:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q    [NUM_CH];
    state_t           state_d    [NUM_CH];
    logic [CNT_W-1:0] lat_q      [NUM_CH];
    logic [CNT_W-1:0] lat_d      [NUM_CH];
    logic [CNT_W-1:0] iter_q     [NUM_CH];
    logic [CNT_W-1:0] iter_d     [NUM_CH];
    logic [CNT_W-1:0] stall_q    [NUM_CH];
    logic [CNT_W-1:0] stall_d    [NUM_CH];
    logic [CNT_W-1:0] snap_lat_q   [NUM_CH];
    logic [CNT_W-1:0] snap_lat_d   [NUM_CH];
    logic [CNT_W-1:0] snap_iter_q  [NUM_CH];
    logic [CNT_W-1:0] snap_iter_d  [NUM_CH];
    logic [CNT_W-1:0] snap_stall_q [NUM_CH];
    logic [CNT_W-1:0] snap_stall_d [NUM_CH];
    logic [CNT_W-1:0] inv_q      [NUM_CH];
    logic [CNT_W-1:0] inv_d      [NUM_CH];
    logic [NUM_CH-1:0] done_d;
    logic [NUM_CH-1:0] perr_d;
    logic [CNT_W-1:0]  rd_mux_c;

    // Saturating increment by a single bit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
        if (b && (a != '1)) begin
            return a + CNT_W'(1);
        end
        return a;
    endfunction

    // Next-state and counter update for every channel.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        iter_d       = iter_q;
        stall_d      = stall_q;
        snap_lat_d   = snap_lat_q;
        snap_iter_d  = snap_iter_q;
        snap_stall_d = snap_stall_q;
        inv_d        = inv_q;
        done_d       = '0;
        perr_d       = proto_err;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clear) begin
                state_d[c]      = IDLE;
                lat_d[c]        = '0;
                iter_d[c]       = '0;
                stall_d[c]      = '0;
                snap_lat_d[c]   = '0;
                snap_iter_d[c]  = '0;
                snap_stall_d[c] = '0;
                inv_d[c]        = '0;
                perr_d[c]       = 1'b0;
            end else begin
                case (state_q[c])
                    IDLE: begin
                        if (ch_start[c]) begin
                            lat_d[c]   = CNT_W'(1);
                            iter_d[c]  = CNT_W'(ch_iter[c]);
                            stall_d[c] = CNT_W'(ch_stall[c]);
                            if (ch_done[c]) begin
                                // Single-cycle invocation completes without entering RUN.
                                snap_lat_d[c]   = CNT_W'(1);
                                snap_iter_d[c]  = CNT_W'(ch_iter[c]);
                                snap_stall_d[c] = CNT_W'(ch_stall[c]);
                                inv_d[c]        = sat_inc(inv_q[c], 1'b1);
                                done_d[c]       = 1'b1;
                            end else begin
                                state_d[c] = RUN;
                            end
                        end else if (ch_done[c]) begin
                            perr_d[c] = 1'b1;
                        end
                    end
                    RUN: begin
                        lat_d[c]   = sat_inc(lat_q[c], 1'b1);
                        iter_d[c]  = sat_inc(iter_q[c], ch_iter[c]);
                        stall_d[c] = sat_inc(stall_q[c], ch_stall[c]);
                        if (ch_done[c]) begin
                            // Snapshot includes the done cycle's own increments.
                            snap_lat_d[c]   = lat_d[c];
                            snap_iter_d[c]  = iter_d[c];
                            snap_stall_d[c] = stall_d[c];
                            inv_d[c]        = sat_inc(inv_q[c], 1'b1);
                            done_d[c]       = 1'b1;
                            state_d[c]      = IDLE;
                        end
                    end
                    default: state_d[c] = IDLE;
                endcase
            end
        end
    end

    // Channel state, counters and status flags.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]      <= IDLE;
                lat_q[c]        <= '0;
                iter_q[c]       <= '0;
                stall_q[c]      <= '0;
                snap_lat_q[c]   <= '0;
                snap_iter_q[c]  <= '0;
                snap_stall_q[c] <= '0;
                inv_q[c]        <= '0;
            end
            ch_busy   <= '0;
            done_evt  <= '0;
            proto_err <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]      <= state_d[c];
                lat_q[c]        <= lat_d[c];
                iter_q[c]       <= iter_d[c];
                stall_q[c]      <= stall_d[c];
                snap_lat_q[c]   <= snap_lat_d[c];
                snap_iter_q[c]  <= snap_iter_d[c];
                snap_stall_q[c] <= snap_stall_d[c];
                inv_q[c]        <= inv_d[c];
                ch_busy[c]      <= (state_d[c] == RUN);
            end
            done_evt  <= done_d;
            proto_err <= perr_d;
        end
    end

    // Read selection from current register values; out-of-range channels read as zero.
    always_comb begin
        rd_mux_c = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                2'd0:    rd_mux_c = snap_lat_q[rd_ch];
                2'd1:    rd_mux_c = snap_iter_q[rd_ch];
                2'd2:    rd_mux_c = snap_stall_q[rd_ch];
                default: rd_mux_c = inv_q[rd_ch];
            endcase
        end
    end

    // Registered read port; a read alongside clear still returns the pre-clear value.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= rd_mux_c;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
            if (clear) begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_loop_profiler.sv
// Directed bench for sobel_loop_profiler: a 32-bit instance for the main
// scenarios and a 4-bit-counter instance for saturation and clear-on-done.
module tb_sobel_loop_profiler;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        clear;
    logic [2:0]  ch_start, ch_done, ch_iter, ch_stall;
    logic [2:0]  ch_busy, done_evt, proto_err;
    logic        rd_en;
    logic [1:0]  rd_ch, rd_sel;
    logic [31:0] rd_data;
    logic        rd_valid;

    logic        clear4;
    logic [2:0]  start4, done4, iter4, stall4;
    logic [2:0]  busy4, evt4, perr4;
    logic        rd_en4;
    logic [1:0]  rd_ch4, rd_sel4;
    logic [3:0]  rd_data4;
    logic        rd_valid4;

    int nvec = 0;
    int nerr = 0;

    sobel_loop_profiler #(.NUM_CH(3), .CNT_W(32), .CH_W(2)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear),
        .ch_start(ch_start), .ch_done(ch_done), .ch_iter(ch_iter), .ch_stall(ch_stall),
        .ch_busy(ch_busy), .done_evt(done_evt), .proto_err(proto_err),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    sobel_loop_profiler #(.NUM_CH(3), .CNT_W(4), .CH_W(2)) dut4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear4),
        .ch_start(start4), .ch_done(done4), .ch_iter(iter4), .ch_stall(stall4),
        .ch_busy(busy4), .done_evt(evt4), .proto_err(perr4),
        .rd_en(rd_en4), .rd_ch(rd_ch4), .rd_sel(rd_sel4),
        .rd_data(rd_data4), .rd_valid(rd_valid4)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [1:0]  ch;
        logic [1:0]  sel;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t rst_vec  [4];
    rd_vec_t post_vec [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] ch, input logic [1:0] sel,
                           input logic [31:0] exp, input string name);
        rd_en  = 1'b1;
        rd_ch  = ch;
        rd_sel = sel;
        step();
        rd_en = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk(name, rd_data, exp);
    endtask

    task automatic do_read4(input logic [1:0] sel, input logic [31:0] exp, input string name);
        rd_en4  = 1'b1;
        rd_ch4  = 2'd0;
        rd_sel4 = sel;
        step();
        rd_en4 = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid4), 32'd1);
        chk(name, 32'(rd_data4), exp);
    endtask

    initial begin
        rst_vec[0] = '{2'd0, 2'd0, 32'd0, "rst_ch0_lat"};
        rst_vec[1] = '{2'd0, 2'd1, 32'd0, "rst_ch0_iter"};
        rst_vec[2] = '{2'd0, 2'd2, 32'd0, "rst_ch0_stall"};
        rst_vec[3] = '{2'd0, 2'd3, 32'd0, "rst_ch0_inv"};

        post_vec[0] = '{2'd1, 2'd0, 32'd20, "ch1_lat"};
        post_vec[1] = '{2'd1, 2'd1, 32'd10, "ch1_iter"};
        post_vec[2] = '{2'd1, 2'd2, 32'd3,  "ch1_stall"};
        post_vec[3] = '{2'd1, 2'd3, 32'd1,  "ch1_inv"};
        post_vec[4] = '{2'd2, 2'd0, 32'd1,  "ch2_lat"};
        post_vec[5] = '{2'd2, 2'd3, 32'd3,  "ch2_inv"};
        post_vec[6] = '{2'd0, 2'd0, 32'd3,  "ch0_lat"};
        post_vec[7] = '{2'd0, 2'd3, 32'd2,  "ch0_inv"};
        post_vec[8] = '{2'd3, 2'd0, 32'd0,  "ch3_lat"};
        post_vec[9] = '{2'd3, 2'd3, 32'd0,  "ch3_inv"};

        ap_rst_n = 1'b0;
        clear = 1'b0; ch_start = '0; ch_done = '0; ch_iter = '0; ch_stall = '0;
        rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
        clear4 = 1'b0; start4 = '0; done4 = '0; iter4 = '0; stall4 = '0;
        rd_en4 = 1'b0; rd_ch4 = '0; rd_sel4 = '0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // Reset state
        chk("rst_busy", 32'(ch_busy), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_evt", 32'(done_evt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_read(rst_vec[i].ch, rst_vec[i].sel, rst_vec[i].exp, rst_vec[i].name);
        end
        step();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);

        // ch1: 20-cycle invocation, 10 iterations, 3 stalls
        for (int k = 1; k <= 20; k++) begin
            ch_start[1] = (k == 1);
            ch_iter[1]  = (k <= 10);
            ch_stall[1] = (k >= 5 && k <= 7);
            ch_done[1]  = (k == 20);
            step();
            if (k == 1)  chk("ch1_busy_run", 32'(ch_busy[1]), 32'd1);
            if (k == 19) chk("ch1_evt_early", 32'(done_evt[1]), 32'd0);
            if (k == 20) begin
                chk("ch1_evt", 32'(done_evt[1]), 32'd1);
                chk("ch1_busy_idle", 32'(ch_busy[1]), 32'd0);
            end
        end
        ch_start[1] = 1'b0; ch_iter[1] = 1'b0; ch_stall[1] = 1'b0; ch_done[1] = 1'b0;
        step();
        chk("ch1_evt_once", 32'(done_evt[1]), 32'd0);

        // ch2: start and done together, then two back-to-back
        ch_start[2] = 1'b1; ch_done[2] = 1'b1;
        step();
        ch_start[2] = 1'b0; ch_done[2] = 1'b0;
        chk("ch2_evt", 32'(done_evt[2]), 32'd1);
        chk("ch2_busy", 32'(ch_busy[2]), 32'd0);
        step();
        chk("ch2_evt_end", 32'(done_evt[2]), 32'd0);
        ch_start[2] = 1'b1; ch_done[2] = 1'b1;
        step();
        chk("ch2_b2b_evt1", 32'(done_evt[2]), 32'd1);
        step();
        ch_start[2] = 1'b0; ch_done[2] = 1'b0;
        chk("ch2_b2b_evt2", 32'(done_evt[2]), 32'd1);
        step();
        chk("ch2_b2b_end", 32'(done_evt[2]), 32'd0);

        // ch0 done while idle
        ch_done[0] = 1'b1;
        step();
        ch_done[0] = 1'b0;
        chk("ch0_perr", 32'(proto_err[0]), 32'd1);
        chk("ch0_perr_noevt", 32'(done_evt[0]), 32'd0);
        step();
        step();
        chk("ch0_perr_sticky", 32'(proto_err[0]), 32'd1);
        do_read(2'd0, 2'd3, 32'd0, "ch0_inv_after_perr");

        // ch0: 5-cycle invocation, then 3-cycle one with a read on its done edge
        for (int k = 1; k <= 5; k++) begin
            ch_start[0] = (k == 1);
            ch_done[0]  = (k == 5);
            step();
        end
        for (int k = 1; k <= 3; k++) begin
            ch_start[0] = (k == 1);
            ch_done[0]  = (k == 3);
            rd_en  = (k == 3);
            rd_ch  = 2'd0;
            rd_sel = 2'd0;
            step();
        end
        ch_start[0] = 1'b0; ch_done[0] = 1'b0; rd_en = 1'b0;
        chk("coincident_rd_valid", 32'(rd_valid), 32'd1);
        chk("coincident_rd_old", rd_data, 32'd5);
        chk("ch0_evt2", 32'(done_evt[0]), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_read(post_vec[i].ch, post_vec[i].sel, post_vec[i].exp, post_vec[i].name);
        end

        // Clear with a simultaneous read returns the pre-clear value
        clear = 1'b1; rd_en = 1'b1; rd_ch = 2'd1; rd_sel = 2'd0;
        step();
        clear = 1'b0; rd_en = 1'b0;
        chk("clear_rd_valid", 32'(rd_valid), 32'd1);
        chk("clear_rd_old", rd_data, 32'd20);
        chk("clear_perr", 32'(proto_err), 32'd0);
        step();
        chk("rd_hold_valid", 32'(rd_valid), 32'd0);
        chk("rd_hold_data", rd_data, 32'd20);
        do_read(2'd1, 2'd0, 32'd0, "ch1_lat_cleared");
        do_read(2'd1, 2'd3, 32'd0, "ch1_inv_cleared");

        // 4-bit instance: saturation at 15
        for (int k = 1; k <= 20; k++) begin
            start4[0] = (k == 1);
            iter4[0]  = 1'b1;
            done4[0]  = (k == 20);
            step();
        end
        start4[0] = 1'b0; iter4[0] = 1'b0; done4[0] = 1'b0;
        chk("sat_evt", 32'(evt4[0]), 32'd1);
        do_read4(2'd0, 32'd15, "sat_lat");
        do_read4(2'd1, 32'd15, "sat_iter");
        do_read4(2'd3, 32'd1,  "sat_inv");

        // 4-bit instance: clear on the done cycle discards the completion
        for (int k = 1; k <= 20; k++) begin
            start4[0] = (k == 1);
            done4[0]  = (k == 20);
            clear4    = (k == 20);
            step();
            if (k == 10) chk("clr_busy_run", 32'(busy4[0]), 32'd1);
        end
        start4[0] = 1'b0; done4[0] = 1'b0; clear4 = 1'b0;
        chk("clr_no_evt", 32'(evt4[0]), 32'd0);
        chk("clr_busy", 32'(busy4[0]), 32'd0);
        step();
        chk("clr_no_evt_late", 32'(evt4[0]), 32'd0);
        do_read4(2'd3, 32'd0, "clr_inv");
        do_read4(2'd0, 32'd0, "clr_lat");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
